// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIG_W      = 4;
    localparam int unsigned SCR_W      = NUM_DIGITS * DIG_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [13:0] BCD_MAX    = 14'd9999;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd_word_t;

    // Replace leading zeros in d3..d1 with the blank code; d0 always shows.
    function automatic bcd_word_t blank_leading(input bcd_word_t w);
        bcd_word_t r;
        r = w;
        if (w.d3 == 4'd0) begin
            r.d3 = BLANK_CODE;
            if (w.d2 == 4'd0) begin
                r.d2 = BLANK_CODE;
                if (w.d1 == 4'd0) begin
                    r.d1 = BLANK_CODE;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    assign adj_c = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Bit-serial binary-to-BCD converter (double dabble), one bit per clock.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [SCR_W-1:0] scr_q, scr_d, adj_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ovf_d;
    bcd_word_t        dig_q, dig_d;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (scr_q[DIG_W*i +: DIG_W]),
            .adj_c (adj_c[DIG_W*i +: DIG_W])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, iteration datapath and result load.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        ovf_d   = ovf;
        dig_d   = dig_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    sat_d   = (bin > BIN_W'(BCD_MAX));
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = {adj_c[SCR_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    ovf_d   = sat_q;
                    dig_d   = sat_q ? bcd_word_t'({4{4'd9}}) : bcd_word_t'(scr_d);
`ifdef LEADING_ZERO_BLANK_EN
                    dig_d   = blank_leading(dig_d);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; digits hold between completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            scr_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
            ovf   <= 1'b0;
            dig_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            bin_q <= bin_d;
            scr_q <= scr_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            ovf   <= ovf_d;
            dig_q <= dig_d;
            busy  <= (state_d == SHIFT);
            done  <= (state_d == DONE);
        end
    end

    assign d0 = dig_q.d0;
    assign d1 = dig_q.d1;
    assign d2 = dig_q.d2;
    assign d3 = dig_q.d3;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It converts a binary servo position/angle value into four 4-bit BCD digits. Those digits drive the data inputs (A0..A3) of the 4x1 4-bit display multiplexer directly downstream. Digit outputs are registered and held stable between conversions, so the display scan never shows partial results.

Parameters:
BIN_W, 14, width of binary input (max 16383; 14 bits is the minimum that covers 9999)
NUM_DIGITS, 4, number of BCD digits produced (fixed at 4 for this display; parameter exists for the shared constants only)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  request conversion; sampled only in IDLE
BIN  input  BIN_W  binary value; captured on the edge that accepts START
BUSY  output  1  high while a conversion is in progress (SHIFT state)
DONE  output  1  one-cycle pulse when new digits are valid
OVF  output  1  set when captured BIN > 9999; held until next completion
D0  output  4  ones digit
D1  output  4  tens digit
D2  output  4  hundreds digit
D3  output  4  thousands digit

Behaviour:
- Reset: asynchronous on RST_N low; all outputs and state go to 0 (state = IDLE).
- States:
  - IDLE: on START=1, capture BIN into shift register, clear BCD scratch, load bit counter = BIN_W, go to SHIFT.
  - SHIFT: each edge performs one iteration. First, add 3 to every scratch digit >= 5. Then shift {scratch, bin} left by 1 and decrement the counter. At counter = 1, go to DONE.
  - DONE: DONE = 1 for exactly one cycle, then go to IDLE.
- Output update: D0..D3 and OVF load on the edge that enters DONE, using the final scratch values.
- Latency: START accepted at edge 0 -> BIN_W iterations on edges 1..BIN_W -> DONE high in the cycle after edge BIN_W. Throughput is one conversion per BIN_W+2 cycles.
- BUSY: 1 exactly in SHIFT.
- Overflow: the BIN > 9999 compare is made at capture. If true, the completion loads D3..D0 = 9,9,9,9 and OVF = 1; otherwise OVF = 0.
- Width: the scratch register is 16 bits (4 digits); the shifted-out MSB beyond the thousands digit is discarded. Correctness for values above 9999 is not required because of the saturation rule above.
- START while BUSY or in DONE: ignored, with no queuing. BIN changes after capture have no effect.
- START held high continuously: a new conversion begins each time IDLE is re-entered.
- Reset mid-conversion: abort immediately; digits return to 0 and no DONE pulse is produced.
- Between completions D0..D3 and OVF hold their previous values, including during SHIFT.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: at load, each leading-zero digit among D3, D2, D1 outputs BLANK_CODE (4'hF). Scanning runs from D3 downward and stops at the first nonzero digit. D0 is never blanked, so value 0 shows as F,F,F,0. The downstream 7-segment decoder treats 4'hF as all segments off.
- Undefined: raw zero digits are output and no blank code is ever produced.

Decomposition:
- Shared package/include holds:
  - state encoding constants: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2
  - BLANK_CODE = 4'hF
  - BCD_MAX = 14'd9999
  - NUM_DIGITS = 4
- One combinational sub-module, bcd_add3: 4-bit in, 4-bit out, adds 3 when in >= 5. Instantiated NUM_DIGITS times in the iteration path.

Test Plan:
- Reset, then BIN=0, START pulse -> DONE after 14 cycles; D3..D0 = 0,0,0,0; OVF=0; BUSY high for exactly 14 cycles.
- BIN=1234 -> D3..D0 = 1,2,3,4. BIN=9999 -> 9,9,9,9 with OVF=0. BIN=5 -> 0,0,0,5 (macro off).
- BIN=10000 and BIN=16383 -> D3..D0 = 9,9,9,9 with OVF=1. A following conversion of 42 -> 0,0,4,2 with OVF cleared.
- Conversion of 1234, then a second START with BIN=777 pulsed mid-BUSY and BIN changed to 555 mid-BUSY -> exactly one DONE with 1,2,3,4. D outputs stay at their previous values until that DONE.
- RST_N low at iteration 7 of BIN=8765 -> outputs 0 immediately, no DONE. After release, START with BIN=8765 -> 8,7,6,5.
- With LEADING_ZERO_BLANK_EN: BIN=7 -> F,F,F,7; BIN=0 -> F,F,F,0; BIN=305 -> F,3,0,5; BIN=1000 -> 1,0,0,0.
